// File: rtl/booth_mult_seq_if.sv
// Handshake and operand/result bundle for booth_mult_seq.
// Master drives the request side, slave returns status and product.
interface booth_mult_seq_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 start;
  logic                 tc;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   product;

  modport master (
    output start, tc, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, tc, a, b,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned, one Booth step per clock.
// Operands are widened by one bit so both modes run through the same signed datapath.
module booth_mult_seq #(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  booth_mult_seq_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIDTH + 2);

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [WIDTH+1:0]    acc_q;
  logic [WIDTH:0]      q_q;
  logic                qm1_q;
  logic [WIDTH:0]      m_q;
  logic [CW-1:0]       cnt_q;
  logic                done_q;
  logic [2*WIDTH-1:0]  product_q;

  logic [WIDTH+1:0]    m_ext;
  logic [WIDTH+1:0]    sum;
  logic [WIDTH+1:0]    acc_n;
  logic [WIDTH:0]      q_n;
  logic                qm1_n;
  logic                last;

  // One Booth step: add/subtract M, then arithmetic shift of {A, Q, Q_-1}
  always_comb begin
    m_ext = {m_q[WIDTH], m_q};
    sum   = acc_q;
    unique case ({q_q[0], qm1_q})
      2'b01:   sum = acc_q + m_ext;
      2'b10:   sum = acc_q - m_ext;
      default: sum = acc_q;
    endcase
    {acc_n, q_n, qm1_n} = $signed({sum, q_q, qm1_q}) >>> 1;
    last = (cnt_q == CW'(1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last)      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = (state_q == RUN);
    bus.done    = done_q;
    bus.product = product_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            m_q   <= bus.tc ? {bus.a[WIDTH-1], bus.a} : {1'b0, bus.a};
            q_q   <= bus.tc ? {bus.b[WIDTH-1], bus.b} : {1'b0, bus.b};
            qm1_q <= 1'b0;
            acc_q <= '0;
            cnt_q <= CW'(WIDTH + 1);
          end
        end
        RUN: begin
          acc_q <= acc_n;
          q_q   <= q_n;
          qm1_q <= qm1_n;
          cnt_q <= cnt_q - CW'(1);
          if (last) begin
            // Low 2*WIDTH bits of {A, Q} after the final step
            product_q <= {acc_n[WIDTH-2:0], q_n};
            done_q    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq at WIDTH=4 and WIDTH=8: corner table,
// handshake timing, busy protection, back-to-back, async reset and random ops.
module tb_booth_mult_seq;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  booth_mult_seq_if #(.WIDTH(4)) if4 ();
  booth_mult_seq_if #(.WIDTH(8)) if8 ();

  booth_mult_seq #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(if4));
  booth_mult_seq #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       tc;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] ref_mul8(input logic [7:0] a, input logic [7:0] b, input logic tc);
    int ea;
    int eb;
    ea = tc ? int'($signed(a)) : int'(a);
    eb = tc ? int'($signed(b)) : int'(b);
    return 16'(ea * eb);
  endfunction

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic tc,
                     output logic [7:0] p, output int lat);
    @(negedge clk);
    if4.a = a; if4.b = b; if4.tc = tc; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    if4.a = ~a; if4.b = ~b; if4.tc = ~tc;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if4.done) begin lat = k; break; end
    end
    p = if4.product;
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic tc,
                     output logic [15:0] p, output int lat);
    @(negedge clk);
    if8.a = a; if8.b = b; if8.tc = tc; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    if8.a = 8'($urandom); if8.b = 8'($urandom); if8.tc = 1'($urandom);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (if8.done) begin lat = k; break; end
    end
    p = if8.product;
  endtask

  initial begin
    logic [7:0]  p4;
    logic [15:0] p8;
    logic [15:0] e8;
    logic [7:0]  exp_b2b[3];
    int          lat;
    int          ndone;
    int          rfail;

    passed = 0;
    total  = 0;
    rst = 1'b0;
    if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.tc = 1'b0;
    if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.tc = 1'b0;

    vecs[0] = '{a: 4'h8, b: 4'h8, tc: 1'b1, exp: 8'h40};
    vecs[1] = '{a: 4'h7, b: 4'h8, tc: 1'b1, exp: 8'hC8};
    vecs[2] = '{a: 4'hF, b: 4'h1, tc: 1'b1, exp: 8'hFF};
    vecs[3] = '{a: 4'hF, b: 4'hF, tc: 1'b0, exp: 8'hE1};
    vecs[4] = '{a: 4'hF, b: 4'h0, tc: 1'b0, exp: 8'h00};
    vecs[5] = '{a: 4'h8, b: 4'h2, tc: 1'b0, exp: 8'h10};
    vecs[6] = '{a: 4'h8, b: 4'h7, tc: 1'b0, exp: 8'h38};
    vecs[7] = '{a: 4'hF, b: 4'hF, tc: 1'b1, exp: 8'h01};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy4", 32'(if4.busy), 32'd0);
    check("reset_done4", 32'(if4.done), 32'd0);
    check("reset_prod4", 32'(if4.product), 32'd0);
    check("reset_prod8", 32'(if8.product), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].tc, p4, lat);
      check($sformatf("vec%0d_prod", i), 32'(p4), 32'(vecs[i].exp));
      check($sformatf("vec%0d_lat", i), 32'(lat), 32'd5);
    end

    // Handshake timing, WIDTH=4: capture edge E, done only after E+5
    @(negedge clk);
    if4.a = 4'd3; if4.b = 4'd5; if4.tc = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    check("t4_busy_e0", 32'(if4.busy), 32'd1);
    check("t4_done_e0", 32'(if4.done), 32'd0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("t4_busy_e%0d", k), 32'(if4.busy), 32'(k < 5));
      check($sformatf("t4_done_e%0d", k), 32'(if4.done), 32'(k == 5));
      if (k == 5) check("t4_prod", 32'(if4.product), 32'h0F);
    end

    // Same at WIDTH=8: done at E+9
    @(negedge clk);
    if8.a = 8'd200; if8.b = 8'd100; if8.tc = 1'b0; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      check($sformatf("t8_busy_e%0d", k), 32'(if8.busy), 32'(k < 9));
      check($sformatf("t8_done_e%0d", k), 32'(if8.done), 32'(k == 9));
      if (k == 9) check("t8_prod", 32'(if8.product), 32'd20000);
    end

    // Busy protection: extra starts mid-run are ignored
    @(negedge clk);
    if4.a = 4'd3; if4.b = 4'd5; if4.tc = 1'b1; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); #1;
    if4.a = 4'd7; if4.b = 4'd7; if4.start = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("bp_done", 32'(if4.done), 32'd1);
    check("bp_prod", 32'(if4.product), 32'h0F);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (if4.done) ndone++;
    end
    check("bp_no_second_done", 32'(ndone), 32'd0);

    // Back-to-back with start held high
    exp_b2b[0] = 8'h0F; exp_b2b[1] = 8'hFA; exp_b2b[2] = 8'hDC;
    @(negedge clk);
    if4.tc = 1'b1; if4.a = 4'd3; if4.b = 4'd5; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.a = 4'hE; if4.b = 4'd3;
    for (int n = 0; n < 3; n++) begin
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
        @(posedge clk); #1;
        if (if4.done) begin lat = k; break; end
      end
      check($sformatf("b2b%0d_seen", n), 32'(lat > 0), 32'd1);
      check($sformatf("b2b%0d_prod", n), 32'(if4.product), 32'(exp_b2b[n]));
      @(posedge clk); #1;
      if (n == 0) begin if4.a = 4'd6; if4.b = 4'hA; end
      if (n == 1) if4.start = 1'b0;
    end
    repeat (8) @(posedge clk);

    // Asynchronous reset two cycles into a multiply
    @(negedge clk);
    if4.a = 4'd5; if4.b = 4'd3; if4.tc = 1'b0; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("arst_busy", 32'(if4.busy), 32'd0);
    check("arst_done", 32'(if4.done), 32'd0);
    check("arst_prod4", 32'(if4.product), 32'd0);
    check("arst_prod8", 32'(if8.product), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (if4.done || if4.busy) ndone++;
    end
    check("arst_quiet_after", 32'(ndone), 32'd0);
    op4(4'd5, 4'd3, 1'b0, p4, lat);
    check("arst_next_prod", 32'(p4), 32'h0F);
    check("arst_next_lat", 32'(lat), 32'd5);

    // Random operations at WIDTH=8 against arithmetic model
    rfail = 0;
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic       rt;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rt = 1'($urandom);
      e8 = ref_mul8(ra, rb, rt);
      op8(ra, rb, rt, p8, lat);
      if (rfail < 10 || (p8 === e8 && lat == 9)) begin
        check($sformatf("rnd%0d_prod a=%0h b=%0h tc=%0d", i, ra, rb, rt), 32'(p8), 32'(e8));
        check($sformatf("rnd%0d_lat", i), 32'(lat), 32'd9);
        if (p8 !== e8 || lat != 9) rfail++;
      end else begin
        total++;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
